// File: rtl/timer_pkg.sv
// Shared types for the tick timer: FSM state encoding.
package timer_pkg;

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_RUNNING = 1'b1
   } timer_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Programmable prescaler: counts period+1 enabled clocks between tick enables.
module tick_prescaler #(
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic                  load,
   input  logic [PRESCALE_W-1:0] period,
   output logic                  tick_en
);

   logic [PRESCALE_W-1:0] pre_cnt;

   assign tick_en = ena && (pre_cnt == '0);

   // Reload on restart or when a tick fires, so period is live-sampled each tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt <= '0;
      end else if (load || tick_en) begin
         pre_cnt <= period;
      end else if (ena) begin
         pre_cnt <= pre_cnt - PRESCALE_W'(1);
      end
   end

endmodule

// File: rtl/timer_ntick.sv
// Modulo-N_TICKS tick sequencer with prescaler, pause, restart and one-shot mode.
module timer_ntick
   import timer_pkg::*;
#(
   parameter int N_TICKS    = 8,
   parameter int PRESCALE_W = 16,
   parameter int AUTO_START = 1,
   localparam int TICK_W    = $clog2(N_TICKS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic                  start,
   input  logic                  oneshot,
   input  logic [PRESCALE_W-1:0] period,
   output logic [TICK_W-1:0]     tick_out,
   output logic                  tick,
   output logic                  wrap,
   output logic                  busy
);

   localparam logic [TICK_W-1:0] LAST_TICK   = TICK_W'(N_TICKS - 1);
   localparam timer_state_t      RESET_STATE = (AUTO_START != 0) ? S_RUNNING : S_IDLE;

   timer_state_t state;
   logic         oneshot_q;
   logic         tick_en;

   tick_prescaler #(
      .PRESCALE_W(PRESCALE_W)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .ena    (ena && (state == S_RUNNING)),
      .load   (start),
      .period (period),
      .tick_en(tick_en)
   );

   assign busy = (state == S_RUNNING);

   // Wrap is an explicit compare so non-power-of-two N_TICKS works.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RESET_STATE;
         tick_out  <= '0;
         tick      <= 1'b0;
         wrap      <= 1'b0;
         oneshot_q <= 1'b0;
      end else begin
         tick <= 1'b0;
         wrap <= 1'b0;
         if (start) begin
            state     <= S_RUNNING;
            tick_out  <= '0;
            oneshot_q <= oneshot;
         end else if (tick_en) begin
            tick <= 1'b1;
            if (tick_out == LAST_TICK) begin
               tick_out <= '0;
               wrap     <= 1'b1;
               if (oneshot_q) begin
                  state <= S_IDLE;
               end
            end else begin
               tick_out <= tick_out + TICK_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_timer_ntick.sv
// Self-checking bench: a default 8-tick instance and a 5-tick AUTO_START=0 instance share stimulus.
module tb_timer_ntick;

   typedef struct {
      bit  run;
      int  idx;
      int  rem;
      bit  os;
      bit  tick;
      bit  wrap;
   } mdl_t;

   typedef struct {
      bit       ena;
      int       period;
      int       exp_out;
      bit       exp_tick;
      bit       exp_wrap;
      bit       exp_busy;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ena;
   logic        start;
   logic        oneshot;
   logic [15:0] period;

   logic [2:0]  tick_out8;
   logic        tick8, wrap8, busy8;
   logic [2:0]  tick_out5;
   logic        tick5, wrap5, busy5;

   int   errors = 0;
   int   checks = 0;
   mdl_t m8, m5;
   vec_t vecs[20];

   always #5 clk = ~clk;

   timer_ntick #(.N_TICKS(8), .PRESCALE_W(16), .AUTO_START(1)) dut8 (
      .clk(clk), .rst(rst), .ena(ena), .start(start), .oneshot(oneshot), .period(period),
      .tick_out(tick_out8), .tick(tick8), .wrap(wrap8), .busy(busy8)
   );

   timer_ntick #(.N_TICKS(5), .PRESCALE_W(16), .AUTO_START(0)) dut5 (
      .clk(clk), .rst(rst), .ena(ena), .start(start), .oneshot(oneshot), .period(period),
      .tick_out(tick_out5), .tick(tick5), .wrap(wrap5), .busy(busy5)
   );

   // Reference: each tick is due after period+1 enabled running clocks; index advances modulo n.
   function automatic mdl_t mdl_reset(bit auto_start);
      mdl_t r;
      r.run = auto_start; r.idx = 0; r.rem = 0; r.os = 0; r.tick = 0; r.wrap = 0;
      return r;
   endfunction

   function automatic mdl_t mdl_step(mdl_t m, int n, bit e, bit s, bit o, int p);
      mdl_t r = m;
      r.tick = 0;
      r.wrap = 0;
      if (s) begin
         r.run = 1; r.idx = 0; r.rem = p; r.os = o;
      end else if (m.run && e) begin
         if (m.rem == 0) begin
            r.rem  = p;
            r.tick = 1;
            r.idx  = (m.idx + 1) % n;
            r.wrap = (r.idx == 0);
            if (r.wrap && m.os) r.run = 0;
         end else begin
            r.rem = m.rem - 1;
         end
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit e, input bit s, input bit o, input int p);
      ena     = e;
      start   = s;
      oneshot = o;
      period  = p[15:0];
   endtask

   task automatic stepClock();
      @(posedge clk);
      if (rst) begin
         m8 = mdl_reset(1'b1);
         m5 = mdl_reset(1'b0);
      end else begin
         m8 = mdl_step(m8, 8, ena, start, oneshot, int'(period));
         m5 = mdl_step(m5, 5, ena, start, oneshot, int'(period));
      end
      #1;
   endtask

   task automatic checkModels();
      checkOutput("n8.tick_out", int'(tick_out8), m8.idx);
      checkOutput("n8.tick",     int'(tick8),     int'(m8.tick));
      checkOutput("n8.wrap",     int'(wrap8),     int'(m8.wrap));
      checkOutput("n8.busy",     int'(busy8),     int'(m8.run));
      checkOutput("n5.tick_out", int'(tick_out5), m5.idx);
      checkOutput("n5.tick",     int'(tick5),     int'(m5.tick));
      checkOutput("n5.wrap",     int'(wrap5),     int'(m5.wrap));
      checkOutput("n5.busy",     int'(busy5),     int'(m5.run));
   endtask

   task automatic waitTick8(input string name, input int want);
      int n = 0;
      do begin
         stepClock();
         n++;
      end while (!tick8 && n < 20);
      checkOutput(name, n, want);
   endtask

   initial begin
      int n;
      int held;
      int wraps;

      for (int k = 0; k < 20; k++) begin
         vecs[k].ena      = 1'b1;
         vecs[k].period   = 0;
         vecs[k].exp_out  = (k + 1) % 8;
         vecs[k].exp_tick = 1'b1;
         vecs[k].exp_wrap = ((k + 1) % 8 == 0);
         vecs[k].exp_busy = 1'b1;
      end

      rst = 1'b1;
      applyStimulus(1, 0, 0, 0);
      m8 = mdl_reset(1'b1);
      m5 = mdl_reset(1'b0);
      stepClock();
      stepClock();
      checkOutput("reset.n8.tick_out", int'(tick_out8), 0);
      checkOutput("reset.n8.busy", int'(busy8), 1);
      checkOutput("reset.n5.busy", int'(busy5), 0);
      rst = 1'b0;

      // Free-running default count straight out of reset
      for (int k = 0; k < 20; k++) begin
         applyStimulus(vecs[k].ena, 0, 0, vecs[k].period);
         stepClock();
         checkOutput("tbl.tick_out", int'(tick_out8), vecs[k].exp_out);
         checkOutput("tbl.tick",     int'(tick8),     int'(vecs[k].exp_tick));
         checkOutput("tbl.wrap",     int'(wrap8),     int'(vecs[k].exp_wrap));
         checkOutput("tbl.busy",     int'(busy8),     int'(vecs[k].exp_busy));
         checkModels();
      end

      // Periodic run with period=3
      applyStimulus(1, 1, 0, 3);
      stepClock();
      checkModels();
      applyStimulus(1, 0, 0, 3);
      waitTick8("p3.first_tick_edges", 4);
      checkModels();
      for (int k = 0; k < 40; k++) begin
         stepClock();
         checkModels();
      end

      // One-shot pass with period=1
      applyStimulus(1, 1, 1, 1);
      stepClock();
      checkModels();
      applyStimulus(1, 0, 0, 1);
      wraps = 0;
      for (int k = 0; k < 36; k++) begin
         stepClock();
         checkModels();
         if (wrap5) begin
            wraps++;
            checkOutput("os5.busy_at_wrap", int'(busy5), 0);
         end
      end
      checkOutput("os5.wrap_count", wraps, 1);
      checkOutput("os5.idle_tick_out", int'(tick_out5), 0);

      // Pause mid-prescale with period=2
      applyStimulus(1, 1, 0, 2);
      stepClock();
      applyStimulus(1, 0, 0, 2);
      stepClock();
      checkModels();
      held = int'(tick_out8);
      applyStimulus(0, 0, 0, 2);
      n = 0;
      for (int k = 0; k < 10; k++) begin
         stepClock();
         checkModels();
         if (tick8) n++;
      end
      checkOutput("pause.tick_count", n, 0);
      checkOutput("pause.tick_out_held", int'(tick_out8), held);
      applyStimulus(1, 0, 0, 2);
      waitTick8("pause.resume_edges", 2);
      checkModels();

      // Restart while tick_out=5, with ena low in the start cycle
      applyStimulus(1, 1, 0, 1);
      stepClock();
      applyStimulus(1, 0, 0, 1);
      n = 0;
      while (tick_out8 != 3'd5 && n < 40) begin
         stepClock();
         n++;
      end
      checkOutput("restart.reached5", int'(tick_out8), 5);
      applyStimulus(0, 1, 1, 1);
      stepClock();
      checkOutput("restart.tick_out", int'(tick_out8), 0);
      checkOutput("restart.tick", int'(tick8), 0);
      checkModels();
      applyStimulus(1, 0, 0, 1);
      waitTick8("restart.first_tick_edges", 2);
      checkOutput("restart.tick_out1", int'(tick_out8), 1);
      for (int k = 0; k < 20; k++) begin
         stepClock();
         checkModels();
      end
      checkOutput("restart.oneshot_done", int'(busy8), 0);
      applyStimulus(1, 1, 0, 0);
      stepClock();
      checkModels();
      applyStimulus(1, 0, 0, 0);
      for (int k = 0; k < 12; k++) begin
         stepClock();
         checkModels();
      end

      // Asynchronous reset between edges
      #2;
      rst = 1'b1;
      #1;
      m8 = mdl_reset(1'b1);
      m5 = mdl_reset(1'b0);
      checkOutput("arst.n8.tick_out", int'(tick_out8), 0);
      checkOutput("arst.n8.tick", int'(tick8), 0);
      checkOutput("arst.n8.wrap", int'(wrap8), 0);
      checkOutput("arst.n8.busy", int'(busy8), 1);
      checkOutput("arst.n5.tick_out", int'(tick_out5), 0);
      checkOutput("arst.n5.busy", int'(busy5), 0);
      stepClock();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         stepClock();
         checkModels();
      end

      // Randomised stimulus against the reference model
      for (int k = 0; k < 400; k++) begin
         applyStimulus($urandom_range(3, 0) != 0, $urandom_range(24, 0) == 0,
                       $urandom_range(1, 0) != 0, int'($urandom_range(4, 0)));
         stepClock();
         checkModels();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/timer_ntick.md
Name: timer_ntick

Overview:
- Parametrised successor to the fixed 8-tick timer: a modulo-N_TICKS tick counter driven through a programmable prescaler.
- Adds an enable (pause), a synchronous (re)start, periodic or one-shot mode, and single-cycle tick/wrap strobes.
- Used as the generation/step sequencer for the life circuits and any block needing a slow periodic phase.
- With N_TICKS=8, AUTO_START=1, period=0 and ena=1 it reproduces the free-running 8-tick count exactly.

Parameters:
- N_TICKS, 8: number of tick states; tick_out counts 0..N_TICKS-1. Legal range N_TICKS >= 2; need not be a power of two.
- PRESCALE_W, 16: width of the period input.
- AUTO_START, 1: 1 = leave reset in RUNNING, periodic; 0 = leave reset in IDLE.
- TICK_W, $clog2(N_TICKS): derived localparam, not overridable.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  count enable; 0 freezes all counting state.
- start  in  1  synchronous (re)start pulse.
- oneshot  in  1  mode, sampled only when start=1: 1 = one pass, 0 = periodic.
- period  in  PRESCALE_W  clocks per tick minus 1; 0 = tick every clock.
- tick_out  out  TICK_W  current tick index.
- tick  out  1  registered strobe: high for the one cycle in which a new tick_out value is first visible.
- wrap  out  1  registered strobe: high with tick when tick_out moves N_TICKS-1 -> 0.
- busy  out  1  high while the state is RUNNING.

Behaviour:
- Reset (async, immediate, no clock needed):
  - tick_out=0, prescale count pre_cnt=0, tick=0, wrap=0, oneshot_q=0.
  - State = RUNNING if AUTO_START=1, else IDLE.
- FSM has two states: IDLE and RUNNING. busy is decoded from state (RUNNING -> 1).
- Priority at each posedge: rst > start > ena-gated counting.
- start=1, from any state and regardless of ena:
  - tick_out<=0, pre_cnt<=period, oneshot_q<=oneshot, state<=RUNNING, tick<=0, wrap<=0.
  - A start while already running is a full restart; phase is discarded.
- RUNNING, ena=1, pre_cnt>0: pre_cnt<=pre_cnt-1, tick<=0, wrap<=0.
- RUNNING, ena=1, pre_cnt==0 (tick event):
  - pre_cnt<=period; period is live-sampled at every tick event.
  - tick<=1.
  - If tick_out==N_TICKS-1: tick_out<=0, wrap<=1. When oneshot_q=1, state<=IDLE in the same edge, so busy falls in the same cycle that wrap is high.
  - Otherwise: tick_out<=tick_out+1, wrap<=0.
  - The wrap is an explicit compare, not natural overflow; this is required for non-power-of-2 N_TICKS.
- RUNNING, ena=0: tick_out, pre_cnt and state hold; tick<=0, wrap<=0. Counting resumes at the exact prescale phase when ena returns.
- IDLE: tick_out and pre_cnt hold; tick=0 and wrap=0. Only start leaves IDLE.
- Tick spacing is period+1 clocks. Wrap spacing is N_TICKS*(period+1) clocks while period is constant.
- Latency:
  - First tick after start is period+1 edges after the start edge.
  - After reset release with AUTO_START=1, pre_cnt=0, so the first ena=1 edge advances tick_out 0->1.
- A change to period mid-tick has no effect until the next tick event reloads pre_cnt.
- No outputs are combinational from inputs. busy is combinational from state only.

Decomposition:
- Package timer_pkg holds the enum timer_state_t {S_IDLE, S_RUNNING}.
- One sub-module, tick_prescaler, owns pre_cnt and the reload/decrement logic.
  - Inputs: clk, rst, ena, load, period.
  - Output: tick_en, combinational, asserted when pre_cnt==0 && ena.
- timer_ntick holds the FSM, tick_out and the registered strobes.

Test Plan:
1. Defaults, AUTO_START=1, period=0, ena=1, run 20 clocks after rst release -> tick_out sequence 1,2,…,7,0,1,…; tick=1 every cycle; wrap=1 exactly in cycles where tick_out=0, every 8th cycle; busy=1 throughout.
2. start with period=3, oneshot=0 -> tick_out advances every 4 clocks, first change 4 edges after start; tick is a one-cycle strobe; wrap every 32 clocks.
3. Instance N_TICKS=5, start with oneshot=1, period=1 -> tick_out 0,1,2,3,4,0 at 2-clock spacing; wrap once, coinciding with busy 1->0; next 20 clocks tick_out=0, tick=0, busy=0.
4. Periodic run with period=2, drop ena for 10 clocks at mid-prescale -> tick_out and phase frozen, no tick; after ena=1 the next tick arrives after exactly the remaining pre_cnt+1 edges.
5. Restart with start while tick_out=5, including once with ena=0 in the same cycle -> tick_out=0 the next cycle, tick=0, full period+1 before tick_out=1; oneshot re-sampled.
6. rst asserted between clock edges during a run -> all outputs reach reset values before the next posedge. With AUTO_START=0: busy=0 and no ticks until start.
